svo_tmds_multi: RTL and testbench
=================================

# svo_tmds_multi

Parametrised multi-channel TMDS/TERC4 encoder for the SVO HDMI output path. It encodes NUM_CH lanes in lockstep from a single per-cycle period mode: video (8b/10b TMDS with signed running disparity), control, data island (TERC4), or guard band. It sits between the timing/pixel pipeline and the 10:1 serialisers and replaces the single-lane DVI-only encoder.

## Interface

Parameters:
- NUM_CH, 3, number of lanes; lane k uses slice [k*W +: W] of every packed bus.
- DISP_W, 5, width of the signed running-disparity counter; must be ≥5.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high; clears all state.
- mode  in  2  period type: 0 control, 1 video, 2 data island, 3 guard band.
- din  in  8*NUM_CH  video byte per lane (mode 1).
- ctrl  in  2*NUM_CH  control bits per lane (mode 0).
- terc4  in  4*NUM_CH  TERC4 nibble per lane (mode 2).
- dout  out  10*NUM_CH  encoded symbol per lane; bit 0 is serialised first.
- mode_out  out  2  mode aligned with dout.
- disp  out  DISP_W*NUM_CH  signed running disparity per lane, aligned with dout.

## Operation

- Two-stage pipeline, identical structure per lane; lanes share mode.
- Stage 1, transition minimisation, registered: N1(din) = popcount. If N1>4, or N1==4 with din[0]==0, use XNOR chaining and q_m[8]=0. Otherwise use XOR chaining and q_m[8]=1. q_m[0]=din[0]. Also register mode, ctrl and terc4.
- Stage 2, DC balance, registered, using N1/N0 counted on q_m[7:0] and cnt = disp, a signed two's-complement count:
  - If cnt==0 or N1==N0: dout = {~q_m8, q_m8, q_m8 ? q_m : ~q_m}. cnt += q_m8 ? (N1−N0) : (N0−N1).
  - Else if (cnt>0 and N1>N0) or (cnt<0 and N0>N1): dout = {1, q_m8, ~q_m}. cnt += 2·q_m8 + (N0−N1).
  - Else: dout = {0, q_m8, q_m}. cnt += −2·(~q_m8) + (N1−N0).
- All disparity arithmetic is signed at DISP_W bits. cnt is always even and within ±16 at DISP_W=5, so no saturation is needed.
- Non-video modes set cnt to 0 on the same edge that emits their symbol.
- Control mode, ctrl 00/01/10/11 → 1101010100 / 0010101011 / 0101010100 / 1010101011.
- Data island mode, TERC4 nibble 0..F →
  - 0–3: 1010011100, 1001100011, 1011100100, 1011100010
  - 4–7: 0101110001, 0100011110, 0110001110, 0100111100
  - 8–B: 1011001100, 0100111001, 0110011100, 1011000110
  - C–F: 1010001110, 1001110001, 0101100011, 1011000011
- Guard band mode: even lane index → 1011001100, odd lane index → 0100110011. Data-island guard bands are produced by the upstream controller using mode 2 on lane 0 plus mode 3 on the other lanes.
- Mode 3 on lanes is lane-index dependent only; din, ctrl and terc4 are ignored.

## Timing

- Latency is exactly 2 clk from input to dout, mode_out and disp. Throughput is one symbol per lane per cycle, with no stalls and no handshake.
- Reset, asynchronous assert: dout=0, mode_out=0, disp=0, and all stage-1 registers =0. Outputs hold these values until 2 edges after release.
- Reset mid-frame discards in-flight symbols. After release, the first valid output appears on the 2nd edge, with disparity starting from 0.
- A mode switch takes effect symbol-exactly. A video symbol following a non-video symbol always starts from cnt==0. A non-video symbol following video emits its fixed code and zeroes cnt, with no dependence on the prior disparity.
- Lanes are fully independent in disparity. A symbol entered on cycle t appears on all lanes on cycle t+2.

## Test plan

- Reset asserted mid-stream, with mode=1 and din=0x55 on all lanes → dout, disp and mode_out read 0 immediately and asynchronously. After release, the first encoded symbol appears 2 edges later with disp=0.
- Video, lane din 0x00 ×3 from cnt 0 → dout 0x100, 0x3FF, 0x100; disp −8, +2, −6.
- Video, din 0xFF from cnt 0 → dout 0x200, disp −8. Lane 1 given 0x00 at the same time → 0x100, disp −8, with lanes independent.
- Control, ctrl=01 on lane 0 and 10 on lane 1 → 0010101011 and 0101010100 after 2 cycles. Prior disp of +2 → disp 0.
- Data island: terc4 0..F swept on lane 0 → the 16 table codes in order, 2-cycle latency, disp 0 throughout.
- Guard band with NUM_CH=4 → lanes 0/2 1011001100, lanes 1/3 0100110011. The next video symbol is encoded from cnt 0.

Source files
------------

// File: rtl/svo_tmds_multi.sv
// svo_tmds_multi: multi-lane HDMI symbol encoder.
// All lanes share one period mode per cycle. Video periods use 8b/10b TMDS
// with a per-lane signed running disparity. Control, data-island (TERC4) and
// guard-band periods emit fixed codes and reset that lane's disparity to 0.
// Two registered stages: transition minimisation, then DC balance / code
// selection. The latency from input to dout/mode_out/disp is exactly 2 clk.
module svo_tmds_multi #(
   parameter int NUM_CH = 3,
   parameter int DISP_W = 5
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [1:0]                 mode,
   input  logic [8*NUM_CH-1:0]        din,
   input  logic [2*NUM_CH-1:0]        ctrl,
   input  logic [4*NUM_CH-1:0]        terc4,
   output logic [10*NUM_CH-1:0]       dout,
   output logic [1:0]                 mode_out,
   output logic [DISP_W*NUM_CH-1:0]   disp
);

   localparam logic [1:0] MODE_CTRL  = 2'd0;
   localparam logic [1:0] MODE_VIDEO = 2'd1;
   localparam logic [1:0] MODE_DATA  = 2'd2;

   localparam logic signed [DISP_W-1:0] ZERO  = '0;
   localparam logic signed [DISP_W-1:0] TWO   = DISP_W'(2);
   localparam logic signed [DISP_W-1:0] EIGHT = DISP_W'(8);

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
      return c;
   endfunction

   // q_m[8] = 1 marks XOR chaining, 0 marks XNOR chaining.
   function automatic logic [8:0] tm_encode(input logic [7:0] d);
      logic [3:0] n1;
      logic       use_xnor;
      logic [8:0] q;
      n1       = popcount8(d);
      use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
      q        = '0;
      q[0]     = d[0];
      for (int i = 1; i < 8; i++)
         q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
      q[8] = ~use_xnor;
      return q;
   endfunction

   function automatic logic [9:0] ctrl_code(input logic [1:0] c);
      logic [9:0] s;
      case (c)
         2'd0:    s = 10'b1101010100;
         2'd1:    s = 10'b0010101011;
         2'd2:    s = 10'b0101010100;
         default: s = 10'b1010101011;
      endcase
      return s;
   endfunction

   function automatic logic [9:0] terc4_code(input logic [3:0] t);
      logic [9:0] s;
      case (t)
         4'h0:    s = 10'b1010011100;
         4'h1:    s = 10'b1001100011;
         4'h2:    s = 10'b1011100100;
         4'h3:    s = 10'b1011100010;
         4'h4:    s = 10'b0101110001;
         4'h5:    s = 10'b0100011110;
         4'h6:    s = 10'b0110001110;
         4'h7:    s = 10'b0100111100;
         4'h8:    s = 10'b1011001100;
         4'h9:    s = 10'b0100111001;
         4'hA:    s = 10'b0110011100;
         4'hB:    s = 10'b1011000110;
         4'hC:    s = 10'b1010001110;
         4'hD:    s = 10'b1001110001;
         4'hE:    s = 10'b0101100011;
         default: s = 10'b1011000011;
      endcase
      return s;
   endfunction

   // valid_s1 keeps the outputs at zero until the first post-reset symbol
   // has actually passed through stage 1.
   logic [1:0] mode_s1;
   logic       valid_s1;

   // Stage 1 shared state: the period mode and pipeline-valid flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_s1  <= 2'd0;
         valid_s1 <= 1'b0;
      end else begin
         mode_s1  <= mode;
         valid_s1 <= 1'b1;
      end
   end

   // Stage 2 shared state: mode aligned with dout.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) mode_out <= 2'd0;
      else       mode_out <= valid_s1 ? mode_s1 : 2'd0;
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      localparam logic [9:0] GUARD_CODE = (k % 2 == 0) ? 10'b1011001100 : 10'b0100110011;

      logic [8:0]               qm_s1;
      logic [1:0]               ctrl_s1;
      logic [3:0]               terc4_s1;
      logic [9:0]               sym_q;
      logic [9:0]               sym_nxt;
      logic signed [DISP_W-1:0] cnt_q;
      logic signed [DISP_W-1:0] cnt_nxt;
      logic [3:0]               n1;
      logic signed [DISP_W-1:0] n1_s;
      logic signed [DISP_W-1:0] bal;
      logic                     q8;
      logic [7:0]               qm;

      // Stage 1 per lane: transition-minimised word plus the side-band inputs.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            qm_s1    <= '0;
            ctrl_s1  <= '0;
            terc4_s1 <= '0;
         end else begin
            qm_s1    <= tm_encode(din[k*8 +: 8]);
            ctrl_s1  <= ctrl[k*2 +: 2];
            terc4_s1 <= terc4[k*4 +: 4];
         end
      end

      // Stage 2 per lane: pick the output symbol and next disparity.
      // bal is N1-N0 of q_m[7:0]; N0-N1 is simply -bal.
      always_comb begin
         qm      = qm_s1[7:0];
         q8      = qm_s1[8];
         n1      = popcount8(qm);
         n1_s    = signed'({{(DISP_W-4){1'b0}}, n1});
         bal     = (n1_s <<< 1) - EIGHT;
         sym_nxt = '0;
         cnt_nxt = ZERO;
         if (valid_s1) begin
            case (mode_s1)
               MODE_VIDEO: begin
                  if ((cnt_q == ZERO) || (bal == ZERO)) begin
                     sym_nxt = {~q8, q8, (q8 ? qm : ~qm)};
                     cnt_nxt = q8 ? (cnt_q + bal) : (cnt_q - bal);
                  end else if (((cnt_q > ZERO) && (bal > ZERO)) ||
                               ((cnt_q < ZERO) && (bal < ZERO))) begin
                     sym_nxt = {1'b1, q8, ~qm};
                     cnt_nxt = cnt_q + (q8 ? TWO : ZERO) - bal;
                  end else begin
                     sym_nxt = {1'b0, q8, qm};
                     cnt_nxt = cnt_q - (q8 ? ZERO : TWO) + bal;
                  end
               end
               MODE_CTRL: sym_nxt = ctrl_code(ctrl_s1);
               MODE_DATA: sym_nxt = terc4_code(terc4_s1);
               default:   sym_nxt = GUARD_CODE;
            endcase
         end
      end

      // Stage 2 per lane: registered symbol and running disparity.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            sym_q <= '0;
            cnt_q <= ZERO;
         end else begin
            sym_q <= sym_nxt;
            cnt_q <= cnt_nxt;
         end
      end

      assign dout[k*10 +: 10]         = sym_q;
      assign disp[k*DISP_W +: DISP_W] = cnt_q;
   end

endmodule

// File: tb/tb_svo_tmds_multi.sv
// Bench for svo_tmds_multi: directed test-plan steps plus randomized traffic,
// checked against a symbol-level reference model with a 2-deep expectation queue.
module tb_svo_tmds_multi;
   localparam int NCH = 4;
   localparam int DW  = 5;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [1:0]            mode;
   logic [8*NCH-1:0]      din;
   logic [2*NCH-1:0]      ctrl;
   logic [4*NCH-1:0]      terc4;
   logic [10*NCH-1:0]     dout;
   logic [1:0]            mode_out;
   logic [DW*NCH-1:0]     disp;

   always #5 clk = ~clk;

   svo_tmds_multi #(.NUM_CH(NCH), .DISP_W(DW)) dut (
      .clk(clk), .reset(reset), .mode(mode), .din(din), .ctrl(ctrl),
      .terc4(terc4), .dout(dout), .mode_out(mode_out), .disp(disp)
   );

   typedef struct {
      logic [10*NCH-1:0] dout;
      logic [DW*NCH-1:0] disp;
      logic [1:0]        mode;
   } exp_t;

   exp_t       pipe[$];
   int         cnt_m[NCH];
   int         checks   = 0;
   int         failures = 0;
   logic [9:0] ctrl_tab[4];
   logic [9:0] terc_tab[16];
   logic [1:0] mode_a;
   logic [7:0] din_a[NCH];
   logic [1:0] ctrl_a[NCH];
   logic [3:0] terc_a[NCH];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] lane_dout(input int k);
      return dout[k*10 +: 10];
   endfunction

   function automatic logic [DW-1:0] lane_disp(input int k);
      return disp[k*DW +: DW];
   endfunction

   // Reference: one symbol per lane straight from the encoding rules, with
   // disparity kept as a plain integer.
   function automatic logic [9:0] model_sym(input int lane, input logic [1:0] m,
                                            input logic [7:0] d, input logic [1:0] c,
                                            input logic [3:0] t);
      logic [9:0] s;
      logic [7:0] q;
      bit         q8;
      bit         xn;
      int         n1;
      int         ones;
      int         zeros;
      s = '0;
      q = '0;
      case (m)
         2'd0: begin s = ctrl_tab[c]; cnt_m[lane] = 0; end
         2'd2: begin s = terc_tab[t]; cnt_m[lane] = 0; end
         2'd3: begin
            s = (lane % 2 == 0) ? 10'b1011001100 : 10'b0100110011;
            cnt_m[lane] = 0;
         end
         default: begin
            n1   = $countones(d);
            xn   = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
            q[0] = d[0];
            for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
            q8    = !xn;
            ones  = $countones(q);
            zeros = 8 - ones;
            if (cnt_m[lane] == 0 || ones == zeros) begin
               s = {~q8, q8, (q8 ? q : ~q)};
               cnt_m[lane] += q8 ? (ones - zeros) : (zeros - ones);
            end else if ((cnt_m[lane] > 0 && ones > zeros) || (cnt_m[lane] < 0 && zeros > ones)) begin
               s = {1'b1, q8, ~q};
               cnt_m[lane] += 2 * int'(q8) + (zeros - ones);
            end else begin
               s = {1'b0, q8, q};
               cnt_m[lane] += -2 * int'(!q8) + (ones - zeros);
            end
         end
      endcase
      return s;
   endfunction

   task automatic clear_model();
      pipe.delete();
      for (int k = 0; k < NCH; k++) cnt_m[k] = 0;
   endtask

   // Drive current stimulus, record its expectation, clock once, and check
   // the symbol entered two cycles earlier when one is due.
   task automatic cycle();
      exp_t e;
      exp_t o;
      int   cv;
      mode = mode_a;
      for (int k = 0; k < NCH; k++) begin
         din[k*8 +: 8]   = din_a[k];
         ctrl[k*2 +: 2]  = ctrl_a[k];
         terc4[k*4 +: 4] = terc_a[k];
      end
      e.mode = mode_a;
      for (int k = 0; k < NCH; k++) begin
         e.dout[k*10 +: 10] = model_sym(k, mode_a, din_a[k], ctrl_a[k], terc_a[k]);
         cv = cnt_m[k];
         e.disp[k*DW +: DW] = cv[DW-1:0];
      end
      pipe.push_back(e);
      @(posedge clk);
      #1;
      if (pipe.size() == 2) begin
         o = pipe.pop_front();
         chk("mode_out", 64'(mode_out), 64'(o.mode));
         for (int k = 0; k < NCH; k++) begin
            chk($sformatf("dout_l%0d", k), 64'(lane_dout(k)), 64'(o.dout[k*10 +: 10]));
            chk($sformatf("disp_l%0d", k), 64'(lane_disp(k)), 64'(o.disp[k*DW +: DW]));
         end
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_dout"}, 64'(dout), 64'd0);
      chk({tag, "_disp"}, 64'(disp), 64'd0);
      chk({tag, "_mode"}, 64'(mode_out), 64'd0);
   endtask

   task automatic set_all(input logic [1:0] m, input logic [7:0] d);
      mode_a = m;
      for (int k = 0; k < NCH; k++) begin
         din_a[k]  = d;
         ctrl_a[k] = 2'd0;
         terc_a[k] = 4'd0;
      end
   endtask

   task automatic randomize_lanes();
      for (int k = 0; k < NCH; k++) begin
         din_a[k]  = 8'($urandom);
         ctrl_a[k] = 2'($urandom);
         terc_a[k] = 4'($urandom);
      end
   endtask

   initial begin
      ctrl_tab = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
      terc_tab = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
                   10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
                   10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
                   10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

      // Power-up reset with video 0x55 presented.
      reset = 1'b0;
      set_all(2'd1, 8'h55);
      mode  = 2'd1;
      din   = {NCH{8'h55}};
      ctrl  = '0;
      terc4 = '0;
      #2 reset = 1'b1;
      #1 chk_zero("rst_init");
      @(posedge clk); #1;
      chk_zero("rst_hold");
      reset = 1'b0;
      clear_model();

      // Some video traffic, then reset asserted asynchronously mid-stream.
      for (int i = 0; i < 6; i++) begin
         mode_a = 2'd1;
         randomize_lanes();
         cycle();
      end
      set_all(2'd1, 8'h55);
      #3 reset = 1'b1;
      #1 chk_zero("rst_async_mid");
      @(posedge clk); #1;
      reset = 1'b0;
      clear_model();
      cycle();
      chk_zero("rst_first_edge");
      cycle();
      chk("rst_first_sym", 64'(lane_dout(0)), 64'h133);
      chk("rst_first_disp", 64'(lane_disp(0)), 64'd0);

      // Directed video / control sequence.
      set_all(2'd0, 8'h00);
      cycle();
      set_all(2'd1, 8'h00);
      cycle();
      cycle();
      chk("v00_a_dout", 64'(lane_dout(0)), 64'h100);
      chk("v00_a_disp", 64'(lane_disp(0)), 64'h18);
      mode_a = 2'd0; ctrl_a[0] = 2'd1; ctrl_a[1] = 2'd2;
      cycle();
      chk("v00_b_dout", 64'(lane_dout(0)), 64'h3FF);
      chk("v00_b_disp", 64'(lane_disp(0)), 64'h02);
      set_all(2'd1, 8'h00);
      din_a[0] = 8'hFF;
      cycle();
      chk("ctrl01_l0", 64'(lane_dout(0)), 64'(10'b0010101011));
      chk("ctrl10_l1", 64'(lane_dout(1)), 64'(10'b0101010100));
      chk("ctrl_disp0", 64'(lane_disp(0)), 64'd0);
      set_all(2'd1, 8'h00);
      cycle();
      chk("vff_l0_dout", 64'(lane_dout(0)), 64'h200);
      chk("vff_l0_disp", 64'(lane_disp(0)), 64'h18);
      chk("v00_l1_dout1", 64'(lane_dout(1)), 64'h100);
      chk("v00_l1_disp1", 64'(lane_disp(1)), 64'h18);
      cycle();
      chk("v00_l1_dout2", 64'(lane_dout(1)), 64'h3FF);
      chk("v00_l1_disp2", 64'(lane_disp(1)), 64'h02);
      cycle();
      chk("v00_l1_dout3", 64'(lane_dout(1)), 64'h100);
      chk("v00_l1_disp3", 64'(lane_disp(1)), 64'h1A);

      // Data-island sweep of lane 0 over all TERC4 nibbles.
      for (int i = 0; i <= 16; i++) begin
         randomize_lanes();
         if (i < 16) begin
            mode_a    = 2'd2;
            terc_a[0] = 4'(i);
         end else begin
            mode_a = 2'd0;
         end
         cycle();
         if (i >= 1) begin
            chk($sformatf("terc4_%0d", i - 1), 64'(lane_dout(0)), 64'(terc_tab[i-1]));
            chk($sformatf("terc4_disp_%0d", i - 1), 64'(lane_disp(0)), 64'd0);
         end
      end

      // Video, then guard band, then video again from zero disparity.
      mode_a = 2'd1;
      randomize_lanes();
      cycle();
      mode_a = 2'd3;
      randomize_lanes();
      cycle();
      set_all(2'd1, 8'h00);
      cycle();
      for (int k = 0; k < NCH; k++)
         chk($sformatf("guard_l%0d", k), 64'(lane_dout(k)),
             (k % 2 == 0) ? 64'(10'b1011001100) : 64'(10'b0100110011));
      set_all(2'd0, 8'h00);
      cycle();
      chk("post_guard_dout", 64'(lane_dout(0)), 64'h100);
      chk("post_guard_disp", 64'(lane_disp(0)), 64'h18);

      // Randomized traffic, biased toward video to exercise disparity.
      for (int i = 0; i < 300; i++) begin
         mode_a = ($urandom_range(0, 2) != 0) ? 2'd1 : 2'($urandom_range(0, 3));
         randomize_lanes();
         cycle();
      end

      set_all(2'd0, 8'h00);
      cycle();
      cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
